branch_resolve: RTL and testbench

//  EX-stage branch resolution unit, downstream of the fetch-stage predictor.

---
 rtl/bp_pkg.sv | 24 ++
 rtl/bp_fifo.sv | 76 +++++++
 rtl/branch_resolve.sv | 164 ++++++++++++++++
 tb/tb_branch_resolve.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg -- types and constants shared by the fetch-stage predictor and the
// EX-stage branch resolution unit.
//   bp_entry_t : one in-flight prediction {pc, taken, target}
//   PC_STEP    : sequential instruction stride
//   IDX_W      : width of the predictor index slice (res_pc[IDX_HI:IDX_LO])
package bp_pkg;

    localparam int          IDX_HI_DEF = 9;
    localparam int          IDX_LO_DEF = 2;
    localparam int          IDX_W      = IDX_HI_DEF - IDX_LO_DEF + 1;
    localparam logic [31:0] PC_STEP    = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } bp_entry_t;

    // Fall-through address of a branch; wraps modulo 2^32.
    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/bp_fifo.sv
// bp_fifo -- DEPTH-entry synchronous FIFO of bp_entry_t with a flush input.
//   clk, rstn   : clock, asynchronous active-low reset
//   clr         : empties the FIFO at the next edge (wins over push/pop)
//   push, pop   : write at tail / drop the head
//   push_data   : entry to write
//   head        : current head entry (valid while !empty, read without latency)
//   full, empty : occupancy flags
//   count       : number of valid entries
// Pointers carry one extra wrap bit so full and empty are distinguished by
// the MSB compare alone; they wrap naturally.
module bp_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clr,
    input  logic                    push,
    input  logic                    pop,
    input  bp_entry_t               push_data,
    output bp_entry_t               head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    bp_entry_t   mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full FIFO is legal when the head leaves in the same
    // cycle: the write lands in the slot being vacated.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// branch_resolve -- EX-stage branch resolution unit.
// Queues predictions issued at IF, compares the head against the branch
// resolved in EX, raises a same-cycle redirect on mispredict and drives the
// predictor update port one cycle after resolution.
// Ports:
//   clk, rstn                         : clock, asynchronous active-low reset
//   push_valid/pc/taken/target        : prediction from IF; push_ready = room
//   res_valid/pc/taken/target         : resolved branch from EX
//   squash                            : pipeline flush, drops everything
//   redirect, redirect_pc             : mispredict restart request
//   record_we/pc/data/pc_result       : registered predictor update
// Build option: define BP_STATS_EN to add stat_branches / stat_mispred
// saturating counters.
module branch_resolve
    import bp_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int IDX_HI = IDX_HI_DEF,
    parameter int IDX_LO = IDX_LO_DEF
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push_valid,
    input  logic [31:0]              push_pc,
    input  logic                     push_taken,
    input  logic [31:0]              push_target,
    output logic                     push_ready,
    input  logic                     res_valid,
    input  logic [31:0]              res_pc,
    input  logic                     res_taken,
    input  logic [31:0]              res_target,
    input  logic                     squash,
    output logic                     redirect,
    output logic [31:0]              redirect_pc,
    output logic                     record_we,
    output logic [IDX_HI-IDX_LO:0]   record_pc,
    output logic                     record_data,
    output logic [31:0]              record_pc_result
`ifdef BP_STATS_EN
    ,
    output logic [31:0]              stat_branches,
    output logic [31:0]              stat_mispred
`endif
);

    bp_entry_t               push_entry;
    bp_entry_t               head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_clr;

    logic                    pred_hit;
    logic                    pred_taken;
    logic [31:0]             pred_target;
    logic                    mispredict;

    logic                    record_we_q, record_we_d;
    logic [IDX_HI-IDX_LO:0]  record_pc_q, record_pc_d;
    logic                    record_data_q, record_data_d;
    logic [31:0]             record_res_q, record_res_d;

    assign push_entry = '{pc: push_pc, taken: push_taken, target: push_target};

    bp_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (fifo_clr),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .push_data (push_entry),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Compare and redirect are purely combinational so fetch can restart in
    // the resolving cycle. A missing or mismatched head counts as a
    // not-taken prediction with target 0.
    always_comb begin
        pred_hit    = !fifo_empty && (head.pc == res_pc);
        pred_taken  = pred_hit && head.taken;
        pred_target = pred_hit ? head.target : 32'd0;
        mispredict  = (pred_taken != res_taken) ||
                      (pred_taken && res_taken && (pred_target != res_target));
        redirect    = res_valid && mispredict && !squash;
        redirect_pc = 32'd0;
        if (redirect) begin
            redirect_pc = res_taken ? res_target : seq_pc(res_pc);
        end
    end

    // A resolving branch frees the head this cycle, so a full queue can
    // still take a new prediction alongside it.
    assign push_ready = !fifo_full || res_valid;
    assign fifo_push  = push_valid && push_ready && !redirect && !squash;
    assign fifo_pop   = res_valid && !squash;
    // Everything behind a mispredicted branch is wrong-path.
    assign fifo_clr   = squash || redirect;

    always_comb begin
        record_we_d   = res_valid && !squash;
        record_pc_d   = record_pc_q;
        record_data_d = record_data_q;
        record_res_d  = record_res_q;
        if (record_we_d) begin
            record_pc_d   = res_pc[IDX_HI:IDX_LO];
            record_data_d = res_taken;
            record_res_d  = res_target;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            record_we_q   <= 1'b0;
            record_pc_q   <= '0;
            record_data_q <= 1'b0;
            record_res_q  <= 32'd0;
        end else begin
            record_we_q   <= record_we_d;
            record_pc_q   <= record_pc_d;
            record_data_q <= record_data_d;
            record_res_q  <= record_res_d;
        end
    end

    assign record_we        = record_we_q;
    assign record_pc        = record_pc_q;
    assign record_data      = record_data_q;
    assign record_pc_result = record_res_q;

`ifdef BP_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispred_q,  stat_mispred_d;

    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        if (res_valid && !squash && (stat_branches_q != 32'hFFFF_FFFF)) begin
            stat_branches_d = stat_branches_q + 32'd1;
        end
        if (redirect && (stat_mispred_q != 32'hFFFF_FFFF)) begin
            stat_mispred_d = stat_mispred_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_branches_q <= 32'd0;
            stat_mispred_q  <= 32'd0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve -- self-checking bench for branch_resolve: directed
// scenarios followed by randomized traffic against a queue-based model.
// Build option BP_STATS_EN is honoured (stat ports connected and checked).
module tb_branch_resolve;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        push_valid;
    logic [31:0] push_pc;
    logic        push_taken;
    logic [31:0] push_target;
    logic        push_ready;
    logic        res_valid;
    logic [31:0] res_pc;
    logic        res_taken;
    logic [31:0] res_target;
    logic        squash;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        record_we;
    logic [7:0]  record_pc;
    logic        record_data;
    logic [31:0] record_pc_result;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;
`endif

    always #5 clk = ~clk;

    branch_resolve #(.DEPTH(DEPTH), .IDX_HI(9), .IDX_LO(2)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .push_valid       (push_valid),
        .push_pc          (push_pc),
        .push_taken       (push_taken),
        .push_target      (push_target),
        .push_ready       (push_ready),
        .res_valid        (res_valid),
        .res_pc           (res_pc),
        .res_taken        (res_taken),
        .res_target       (res_target),
        .squash           (squash),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .record_we        (record_we),
        .record_pc        (record_pc),
        .record_data      (record_data),
        .record_pc_result (record_pc_result)
`ifdef BP_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispred     (stat_mispred)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } pred_t;

    pred_t       mq[$];
    logic        m_we;
    logic [7:0]  m_pc;
    logic        m_data;
    logic [31:0] m_res;

    function automatic logic m_redirect();
        logic        pt;
        logic [31:0] ptg;
        pt  = 1'b0;
        ptg = 32'd0;
        if (mq.size() > 0 && mq[0].pc == res_pc) begin
            pt  = mq[0].taken;
            ptg = mq[0].target;
        end
        if (!res_valid || squash) return 1'b0;
        if (pt != res_taken) return 1'b1;
        return pt && res_taken && (ptg != res_target);
    endfunction

    function automatic logic [31:0] m_redirect_pc();
        if (!m_redirect()) return 32'd0;
        return res_taken ? res_target : res_pc + 32'd4;
    endfunction

    function automatic logic m_push_ready();
        return (mq.size() < DEPTH) || res_valid;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_we   = 1'b0;
        m_pc   = 8'd0;
        m_data = 1'b0;
        m_res  = 32'd0;
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        logic  redir;
        logic  room;
        pred_t e;
        redir = m_redirect();
        room  = m_push_ready();
        if (squash) begin
            mq.delete();
            m_we = 1'b0;
        end else begin
            m_we = res_valid;
            if (res_valid) begin
                m_pc   = res_pc[9:2];
                m_data = res_taken;
                m_res  = res_target;
            end
            if (redir) begin
                mq.delete();
            end else begin
                if (res_valid && mq.size() > 0) void'(mq.pop_front());
                if (push_valid && room) begin
                    e.pc = push_pc; e.taken = push_taken; e.target = push_target;
                    mq.push_back(e);
                end
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        push_valid = 0; push_pc = 0; push_taken = 0; push_target = 0;
        res_valid = 0; res_pc = 0; res_taken = 0; res_target = 0;
        squash = 0;
    endtask

    task automatic drive_push(input logic [31:0] pc, input logic t, input logic [31:0] tg);
        push_valid = 1; push_pc = pc; push_taken = t; push_target = tg;
    endtask

    task automatic drive_res(input logic [31:0] pc, input logic t, input logic [31:0] tg);
        res_valid = 1; res_pc = pc; res_taken = t; res_target = tg;
    endtask

    // Commit current inputs at the next edge; returns 1 ns after it.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rstn = 0;
        #2;
        rstn = 1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        rstn = 0;
        model_reset();
        #12;
        n_checks++; if (push_ready !== 1'b1) $display("FAIL reset_push_ready: got %b want 1", push_ready); else n_pass++;
        n_checks++; if (redirect !== 1'b0) $display("FAIL reset_redirect: got %b want 0", redirect); else n_pass++;
        n_checks++; if (redirect_pc !== 32'd0) $display("FAIL reset_redirect_pc: got %h want 0", redirect_pc); else n_pass++;
        n_checks++; if (record_we !== 1'b0) $display("FAIL reset_record_we: got %b want 0", record_we); else n_pass++;
        n_checks++; if ({record_pc, record_data, record_pc_result} !== 41'd0)
            $display("FAIL reset_record: got %h/%b/%h want 0", record_pc, record_data, record_pc_result); else n_pass++;
        @(negedge clk);
        rstn = 1;
        @(posedge clk);
        #1;
        $display("reset: done");
    endtask

    task automatic test_correct_predict();
        drive_push(32'h100, 1, 32'h140);
        step();
        drive_res(32'h100, 1, 32'h140);
        #2;
        n_checks++; if (redirect !== 1'b0) $display("FAIL t1_redirect: got %b want 0", redirect); else n_pass++;
        step();
        n_checks++; if (record_we !== 1'b1) $display("FAIL t1_record_we: got %b want 1", record_we); else n_pass++;
        n_checks++; if (record_pc !== 8'h40) $display("FAIL t1_record_pc: got %h want 40", record_pc); else n_pass++;
        n_checks++; if (record_data !== 1'b1) $display("FAIL t1_record_data: got %b want 1", record_data); else n_pass++;
        n_checks++; if (record_pc_result !== 32'h140) $display("FAIL t1_record_result: got %h want 140", record_pc_result); else n_pass++;
        $display("correct_predict: pc=100 record_pc=%h", record_pc);
    endtask

    task automatic test_mispredict_taken();
        drive_push(32'h200, 0, 32'h0); step();
        drive_push(32'h204, 1, 32'h280); step();
        drive_push(32'h208, 0, 32'h0); step();
        drive_push(32'h20C, 1, 32'h2A0); step();
        n_checks++; if (int'(dut.u_fifo.count) !== 4) $display("FAIL t2_count_before: got %0d want 4", dut.u_fifo.count); else n_pass++;
        drive_res(32'h200, 1, 32'h180);
        drive_push(32'h210, 0, 32'h0);   // same-cycle push must be dropped
        #2;
        n_checks++; if (redirect !== 1'b1) $display("FAIL t2_redirect: got %b want 1", redirect); else n_pass++;
        n_checks++; if (redirect_pc !== 32'h180) $display("FAIL t2_redirect_pc: got %h want 180", redirect_pc); else n_pass++;
        step();
        n_checks++; if (int'(dut.u_fifo.count) !== 0) $display("FAIL t2_count_after: got %0d want 0", dut.u_fifo.count); else n_pass++;
        $display("mispredict_taken: redirect_pc=180");
    endtask

    task automatic test_mispredict_not_taken();
        drive_push(32'h300, 1, 32'h320); step();
        drive_res(32'h300, 0, 32'h0);
        #2;
        n_checks++; if (redirect !== 1'b1) $display("FAIL t3_redirect: got %b want 1", redirect); else n_pass++;
        n_checks++; if (redirect_pc !== 32'h304) $display("FAIL t3_redirect_pc: got %h want 304", redirect_pc); else n_pass++;
        step();
        $display("mispredict_not_taken: redirect_pc=304");
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) begin
            drive_push(32'h400 + 32'(i * 4), 0, 32'h0);
            step();
        end
        #1;
        n_checks++; if (push_ready !== 1'b0) $display("FAIL t4_push_ready_full: got %b want 0", push_ready); else n_pass++;
        drive_push(32'h500, 1, 32'h540);
        step();
        n_checks++; if (int'(dut.u_fifo.count) !== 4) $display("FAIL t4_count_extra_push: got %0d want 4", dut.u_fifo.count); else n_pass++;
        drive_res(32'h400, 0, 32'h0);
        drive_push(32'h410, 0, 32'h0);
        #2;
        n_checks++; if (push_ready !== 1'b1) $display("FAIL t4_push_ready_pop: got %b want 1", push_ready); else n_pass++;
        n_checks++; if (redirect !== 1'b0) $display("FAIL t4_redirect: got %b want 0", redirect); else n_pass++;
        step();
        n_checks++; if (int'(dut.u_fifo.count) !== 4) $display("FAIL t4_count_push_pop: got %0d want 4", dut.u_fifo.count); else n_pass++;
        $display("full: count=%0d", dut.u_fifo.count);
    endtask

    task automatic test_squash();
        drive_res(32'h404, 1, 32'h999);
        squash = 1;
        #2;
        n_checks++; if (redirect !== 1'b0) $display("FAIL t5_redirect: got %b want 0", redirect); else n_pass++;
        step();
        n_checks++; if (record_we !== 1'b0) $display("FAIL t5_record_we: got %b want 0", record_we); else n_pass++;
        n_checks++; if (int'(dut.u_fifo.count) !== 0) $display("FAIL t5_count: got %0d want 0", dut.u_fifo.count); else n_pass++;
        $display("squash: queue flushed");
    endtask

    task automatic test_empty_resolve_and_async_reset();
        pulse_reset();
        drive_res(32'h500, 1, 32'h600);
        #2;
        n_checks++; if (redirect !== 1'b1) $display("FAIL t6_redirect: got %b want 1", redirect); else n_pass++;
        n_checks++; if (redirect_pc !== 32'h600) $display("FAIL t6_redirect_pc: got %h want 600", redirect_pc); else n_pass++;
        step();
`ifdef BP_STATS_EN
        n_checks++; if (stat_mispred !== 32'd1) $display("FAIL t6_stat_mispred: got %0d want 1", stat_mispred); else n_pass++;
        n_checks++; if (stat_branches !== 32'd1) $display("FAIL t6_stat_branches: got %0d want 1", stat_branches); else n_pass++;
`endif
        drive_push(32'h700, 1, 32'h740); step();
        drive_res(32'h700, 1, 32'h740);  step();
        n_checks++; if (record_we !== 1'b1) $display("FAIL t6_record_we_pre: got %b want 1", record_we); else n_pass++;
        #2;
        rstn = 0;                         // mid-cycle, away from any edge
        model_reset();
        #1;
        n_checks++; if (record_we !== 1'b0) $display("FAIL t6_async_record_we: got %b want 0", record_we); else n_pass++;
        n_checks++; if ({record_pc, record_data, record_pc_result} !== 41'd0)
            $display("FAIL t6_async_record: got %h/%b/%h want 0", record_pc, record_data, record_pc_result); else n_pass++;
        n_checks++; if (push_ready !== 1'b1) $display("FAIL t6_async_push_ready: got %b want 1", push_ready); else n_pass++;
        @(negedge clk);
        rstn = 1;
        @(posedge clk);
        #1;
        $display("empty_resolve_async_reset: done");
    endtask

    task automatic test_random();
        int          pick;
        logic [31:0] tgts [4];
        tgts[0] = 32'h1800; tgts[1] = 32'h1840; tgts[2] = 32'h2000; tgts[3] = 32'hFFFF_FFFC;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if ($urandom_range(99) < 60)
                drive_push(32'h1000 + 32'($urandom_range(7) * 4), 1'($urandom_range(1)),
                           tgts[$urandom_range(3)]);
            if ($urandom_range(99) < 45) begin
                pick = $urandom_range(9);
                if (pick < 7 && mq.size() > 0)
                    drive_res(mq[0].pc, 1'($urandom_range(1)), tgts[$urandom_range(3)]);
                else
                    drive_res(32'h1000 + 32'($urandom_range(7) * 4) + (pick == 9 ? 32'hFFFF_E000 : 32'd0),
                              1'($urandom_range(1)), tgts[$urandom_range(3)]);
            end
            squash = ($urandom_range(99) < 5);
            #2;
            n_checks++; if (redirect !== m_redirect())
                $display("FAIL rnd_redirect c%0d: got %b want %b", cyc, redirect, m_redirect()); else n_pass++;
            n_checks++; if (redirect_pc !== m_redirect_pc())
                $display("FAIL rnd_redirect_pc c%0d: got %h want %h", cyc, redirect_pc, m_redirect_pc()); else n_pass++;
            n_checks++; if (push_ready !== m_push_ready())
                $display("FAIL rnd_push_ready c%0d: got %b want %b", cyc, push_ready, m_push_ready()); else n_pass++;
            step();
            n_checks++; if (int'(dut.u_fifo.count) !== mq.size())
                $display("FAIL rnd_count c%0d: got %0d want %0d", cyc, dut.u_fifo.count, mq.size()); else n_pass++;
            n_checks++; if ({record_we, record_pc, record_data, record_pc_result} !== {m_we, m_pc, m_data, m_res})
                $display("FAIL rnd_record c%0d: got %b/%h/%b/%h want %b/%h/%b/%h", cyc,
                         record_we, record_pc, record_data, record_pc_result, m_we, m_pc, m_data, m_res);
            else n_pass++;
        end
        $display("random: 400 cycles, queue depth now %0d", mq.size());
    endtask

    initial begin
        test_reset();
        test_correct_predict();
        test_mispredict_taken();
        test_mispredict_not_taken();
        test_full();
        test_squash();
        test_empty_resolve_and_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
